alu: RTL and testbench

- 8-bit, 16-function arithmetic/logic unit with a registered 16-bit result and an output-enable.
- Operands `a` and `b` and the 4-bit `command` are sampled on each rising clock edge.
- Result appears on `y` one cycle later.
- When the sampled enable is low, `y` is high-impedance, so the block can share a bus with other drivers.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_if.sv | 13 +
 rtl/alu_core.sv | 44 ++++
 rtl/alu.sv | 40 ++++
 tb/tb_alu.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: opcode encoding and the divide-by-zero value.
package alu_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        INC  = 4'd1,
        SUB  = 4'd2,
        DEC  = 4'd3,
        MUL  = 4'd4,
        DIV  = 4'd5,
        SHL  = 4'd6,
        SHR  = 4'd7,
        AND  = 4'd8,
        OR   = 4'd9,
        INV  = 4'd10,
        NAND = 4'd11,
        NOR  = 4'd12,
        XOR  = 4'd13,
        XNOR = 4'd14,
        BUF  = 4'd15
    } opcode_e;

    localparam logic [2*DATA_W-1:0] DIV_BY_ZERO_RESULT = 16'hFFFF;

endpackage

// File: rtl/alu_if.sv
// Operand/command/result bus of the ALU; y may be released (Z) so other drivers can share it.
interface alu_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [3:0]          command;
    logic                enable;
    logic [2*DATA_W-1:0] y;

    modport master (output a, output b, output command, output enable, input y);
    modport slave  (input a, input b, input command, input enable, output y);
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU function f(command, a, b) on zero-extended unsigned operands.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic [3:0]          command_i,
    output logic [2*DATA_W-1:0] result_o
);

    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;

    assign a_ext = {{DATA_W{1'b0}}, a_i};
    assign b_ext = {{DATA_W{1'b0}}, b_i};

    // NOTE: result_o gets a default before the case so no path can infer a latch.
    always_comb begin
        result_o = '0;
        unique case (opcode_e'(command_i))
            ADD:  result_o = a_ext + b_ext;
            INC:  result_o = a_ext + 1'b1;
            SUB:  result_o = a_ext - b_ext;
            DEC:  result_o = a_ext - 1'b1;
            MUL:  result_o = a_ext * b_ext;
            DIV:  result_o = (b_i == '0) ? DIV_BY_ZERO_RESULT : a_ext / b_ext;
            SHL:  result_o = a_ext << 1;
            SHR:  result_o = a_ext >> 1;
            // Logical ops are byte-wide; the upper byte stays zero.
            AND:  result_o = {{DATA_W{1'b0}}, a_i & b_i};
            OR:   result_o = {{DATA_W{1'b0}}, a_i | b_i};
            INV:  result_o = {{DATA_W{1'b0}}, ~a_i};
            NAND: result_o = {{DATA_W{1'b0}}, ~(a_i & b_i)};
            NOR:  result_o = {{DATA_W{1'b0}}, ~(a_i | b_i)};
            XOR:  result_o = {{DATA_W{1'b0}}, a_i ^ b_i};
            XNOR: result_o = {{DATA_W{1'b0}}, ~(a_i ^ b_i)};
            BUF:  result_o = a_ext;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// ALU top: registers the core result and the output enable, and drives y tri-state.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input logic     clk,
    input logic     rst,
    alu_if.slave    bus
);

    logic [2*DATA_W-1:0] core_result;
    logic [2*DATA_W-1:0] res_d;
    logic [2*DATA_W-1:0] res_q;
    logic                oe_q;

    alu_core #(.DATA_W(DATA_W)) u_core (
        .a_i       (bus.a),
        .b_i       (bus.b),
        .command_i (bus.command),
        .result_o  (core_result)
    );

    // A disabled edge holds the last result so it is not lost while the bus is released.
    assign res_d = bus.enable ? core_result : res_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            oe_q  <= 1'b0;
        end else begin
            res_q <= res_d;
            oe_q  <= bus.enable;
        end
    end

    assign bus.y = oe_q ? res_q : {(2*DATA_W){1'bz}};

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed sequences, a vector table, an exhaustive low-range sweep and random operands.
module tb_alu;
    import alu_pkg::*;

    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_if #(.DATA_W(W)) bus ();

    alu #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  cmd;
        logic [15:0] exp;
        string       name;
    } vec_t;

    // Reference model: the opcode rules computed with plain integer arithmetic.
    function automatic logic [15:0] model(input int cmd, input int a, input int b);
        int r;
        case (cmd)
            0:  r = a + b;
            1:  r = a + 1;
            2:  r = (a - b + 65536) % 65536;
            3:  r = (a - 1 + 65536) % 65536;
            4:  r = a * b;
            5:  r = (b == 0) ? 65535 : a / b;
            6:  r = a * 2;
            7:  r = a / 2;
            8:  r = a & b;
            9:  r = a | b;
            10: r = 255 - a;
            11: r = 255 - (a & b);
            12: r = 255 - (a | b);
            13: r = a ^ b;
            14: r = 255 - (a ^ b);
            default: r = a;
        endcase
        return r[15:0];
    endfunction

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: y=%h expected=%h", name, actual, expected);
        end
    endtask

    // A released bus reads as Z on a four-state simulator and as zero on a two-state one.
    task automatic check_released(input string name, input logic [15:0] actual);
        checks++;
        if (!((actual === 16'hzzzz) || (actual === 16'h0000))) begin
            failures++;
            $display("FAIL %s: y=%h expected=released (Z)", name, actual);
        end
    endtask

    // Drive inputs away from the edge, let one rising edge pass, then sample y.
    task automatic step(input logic r, input logic en, input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd);
        @(negedge clk);
        rst         = r;
        bus.enable  = en;
        bus.a       = a;
        bus.b       = b;
        bus.command = cmd;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.enable  = 1'b1;
        bus.a       = '0;
        bus.b       = '0;
        bus.command = '0;

        vecs.push_back('{8'd255, 8'd255, 4'(ADD),  16'd510,   "add_max"});
        vecs.push_back('{8'd255, 8'd255, 4'(MUL),  16'd65025, "mul_max"});
        vecs.push_back('{8'd255, 8'd0,   4'(INC),  16'd256,   "inc_max"});
        vecs.push_back('{8'h81,  8'd0,   4'(SHL),  16'h0102,  "shl_81"});
        vecs.push_back('{8'h81,  8'd0,   4'(SHR),  16'h0040,  "shr_81"});
        vecs.push_back('{8'd200, 8'd7,   4'(DIV),  16'd28,    "div_200_7"});
        vecs.push_back('{8'd9,   8'd0,   4'(DIV),  16'hFFFF,  "div_by_zero"});
        vecs.push_back('{8'd15,  8'd15,  4'(MUL),  16'd225,   "mul_15"});
        vecs.push_back('{8'd3,   8'd5,   4'(SUB),  16'hFFFE,  "sub_wrap"});
        vecs.push_back('{8'd0,   8'd0,   4'(DEC),  16'hFFFF,  "dec_zero"});
        vecs.push_back('{8'hF0,  8'h3C,  4'(NAND), 16'h00CF,  "nand_mask"});
        vecs.push_back('{8'hF0,  8'h3C,  4'(XNOR), 16'h0033,  "xnor_mask"});
        vecs.push_back('{8'hF0,  8'h3C,  4'(INV),  16'h000F,  "inv_mask"});
        vecs.push_back('{8'hF0,  8'h3C,  4'(BUF),  16'h00F0,  "buf_mask"});
        vecs.push_back('{8'hF0,  8'h3C,  4'(NOR),  16'h0003,  "nor_mask"});
        vecs.push_back('{8'hF0,  8'h3C,  4'(XOR),  16'h00CC,  "xor_mask"});

        // Reset held two cycles with enable high keeps the bus released.
        step(1'b1, 1'b1, 8'd25, 8'd17, 4'(ADD));
        step(1'b1, 1'b1, 8'd25, 8'd17, 4'(ADD));
        check_released("reset_bus", bus.y);
        step(1'b0, 1'b1, 8'd25, 8'd17, 4'(ADD));
        check("reset_release_add", bus.y, 16'h002A);

        // Disable releases the bus; re-enable shows the freshly sampled operation.
        step(1'b0, 1'b0, 8'd20, 8'd10, 4'(ADD));
        check_released("oe_low", bus.y);
        step(1'b0, 1'b1, 8'd25, 8'd17, 4'(ADD));
        check("oe_high_add", bus.y, 16'd42);

        // A disabled edge must not compute: re-enabling with a different op shows only the new op.
        step(1'b0, 1'b1, 8'd7, 8'd6, 4'(MUL));
        check("pre_hold_mul", bus.y, 16'd42);
        step(1'b0, 1'b0, 8'd1, 8'd1, 4'(ADD));
        check_released("hold_low", bus.y);
        step(1'b0, 1'b1, 8'd9, 8'd4, 4'(SUB));
        check("reenable_sub", bus.y, 16'd5);

        // Reset overrides enable while holding a non-zero result.
        step(1'b1, 1'b1, 8'd50, 8'd50, 4'(ADD));
        check_released("reset_overrides_en", bus.y);
        step(1'b0, 1'b1, 8'd50, 8'd50, 4'(ADD));
        check("post_reset_add", bus.y, 16'd100);

        foreach (vecs[i]) begin
            step(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].cmd);
            check(vecs[i].name, bus.y, vecs[i].exp);
        end

        for (int cmd = 0; cmd < 16; cmd++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    step(1'b0, 1'b1, 8'(a), 8'(b), 4'(cmd));
                    check($sformatf("sweep c%0d a%0d b%0d", cmd, a, b), bus.y, model(cmd, a, b));
                end
            end
        end

        for (int n = 0; n < 600; n++) begin
            int ra;
            int rb;
            int rc;
            ra = int'($urandom_range(255, 0));
            rb = int'($urandom_range(255, 0));
            rc = int'($urandom_range(15, 0));
            step(1'b0, 1'b1, 8'(ra), 8'(rb), 4'(rc));
            check($sformatf("rand c%0d a%0d b%0d", rc, ra, rb), bus.y, model(rc, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
